// File: rtl/lcd_hd44780_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : lcd_hd44780_ctrl_if
// Brief  : Request channel into the HD44780 controller, one byte per
//          valid/ready handshake.
// Rev    : 1.0
// ============================================================================
interface lcd_hd44780_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_rs;
    logic [7:0] req_data;

    modport master (
        output req_valid,
        output req_rs,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_rs,
        input  req_data,
        output req_ready
    );
endinterface
`default_nettype wire

// File: rtl/lcd_hd44780_ctrl.sv
`default_nettype none
// ============================================================================
// Module : lcd_hd44780_ctrl
// Brief  : Write-only HD44780 16x2 LCD driver. Runs the power-up init, then
//          writes one command/data byte per handshake with internal timing.
// Rev    : 1.0
// ============================================================================
module lcd_hd44780_ctrl #(
    parameter int POWERUP_CYCLES    = 2_000_000,
    parameter int SETUP_CYCLES      = 3,
    parameter int EN_CYCLES         = 25,
    parameter int CMD_WAIT_CYCLES   = 2_500,
    parameter int CLEAR_WAIT_CYCLES = 100_000
) (
    input  wire logic           CLOCK_50,
    input  wire logic           reset,
    lcd_hd44780_ctrl_if.slave   bus,
    output logic                init_done,
    output logic [7:0]          LCD_DATA,
    output logic                LCD_RS,
    output logic                LCD_RW,
    output logic                LCD_EN,
    output logic                LCD_ON,
    output logic                LCD_BLON
);

    localparam int c_MAX_A  = (POWERUP_CYCLES > CLEAR_WAIT_CYCLES) ? POWERUP_CYCLES : CLEAR_WAIT_CYCLES;
    localparam int c_MAX_B  = (CMD_WAIT_CYCLES > EN_CYCLES) ? CMD_WAIT_CYCLES : EN_CYCLES;
    localparam int c_MAX_C  = (c_MAX_B > SETUP_CYCLES) ? c_MAX_B : SETUP_CYCLES;
    localparam int c_MAX    = (c_MAX_A > c_MAX_C) ? c_MAX_A : c_MAX_C;
    localparam int c_CNT_W  = $clog2(c_MAX + 1);

    // Each state lasts N cycles, so its counter is loaded with N-1.
    localparam logic [c_CNT_W-1:0] c_PWR_LOAD   = c_CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_SETUP_LOAD = c_CNT_W'(SETUP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_EN_LOAD    = c_CNT_W'(EN_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CMD_LOAD   = c_CNT_W'(CMD_WAIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CLEAR_LOAD = c_CNT_W'(CLEAR_WAIT_CYCLES - 1);
    localparam logic [2:0]         c_LAST_IDX   = 3'd5;

    typedef enum logic [2:0] {
        S_PWRUP = 3'd0,
        S_INIT  = 3'd1,
        S_IDLE  = 3'd2,
        S_SETUP = 3'd3,
        S_PULSE = 3'd4,
        S_HOLD  = 3'd5,
        S_WAIT  = 3'd6
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_pwr_armed;
    logic [2:0]           r_idx;
    logic                 r_init_done;
    logic [7:0]           r_data;
    logic                 r_rs;
    logic                 r_en;
    logic                 r_pwr;
    logic                 w_is_clear;
    logic                 w_cnt_zero;

    function automatic logic [7:0] f_init_rom(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: f_init_rom = 8'h38;
            3'd3:             f_init_rom = 8'h0C;
            3'd4:             f_init_rom = 8'h01;
            default:          f_init_rom = 8'h06;
        endcase
    endfunction

    // Clear display and return home need the long post-write wait.
    assign w_is_clear = !r_rs && ((r_data == 8'h01) || (r_data == 8'h02) || (r_data == 8'h03));
    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state     <= S_PWRUP;
            r_cnt       <= '0;
            r_pwr_armed <= 1'b0;
            r_idx       <= '0;
            r_init_done <= 1'b0;
            r_data      <= 8'h00;
            r_rs        <= 1'b0;
            r_en        <= 1'b0;
            r_pwr       <= 1'b0;
        end else begin
            r_pwr <= 1'b1;
            case (r_state)
                S_PWRUP: begin
                    if (!r_pwr_armed) begin
                        r_pwr_armed <= 1'b1;
                        r_cnt       <= c_PWR_LOAD;
                    end else if (w_cnt_zero) begin
                        r_state <= S_INIT;
                        r_idx   <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_INIT: begin
                    r_rs    <= 1'b0;
                    r_data  <= f_init_rom(r_idx);
                    r_cnt   <= c_SETUP_LOAD;
                    r_state <= S_SETUP;
                end
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_rs    <= bus.req_rs;
                        r_data  <= bus.req_data;
                        r_cnt   <= c_SETUP_LOAD;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_cnt_zero) begin
                        r_en    <= 1'b1;
                        r_cnt   <= c_EN_LOAD;
                        r_state <= S_PULSE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_PULSE: begin
                    if (w_cnt_zero) begin
                        r_en    <= 1'b0;
                        r_cnt   <= c_SETUP_LOAD;
                        r_state <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_cnt_zero) begin
                        r_cnt   <= w_is_clear ? c_CLEAR_LOAD : c_CMD_LOAD;
                        r_state <= S_WAIT;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_WAIT: begin
                    if (w_cnt_zero) begin
                        if (r_init_done) begin
                            r_state <= S_IDLE;
                        end else if (r_idx == c_LAST_IDX) begin
                            r_init_done <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_state <= S_INIT;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_PWRUP;
            endcase
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign init_done     = r_init_done;
    assign LCD_DATA      = r_data;
    assign LCD_RS        = r_rs;
    assign LCD_RW        = 1'b0;
    assign LCD_EN        = r_en;
    assign LCD_ON        = r_pwr;
    assign LCD_BLON      = r_pwr;

endmodule
`default_nettype wire

// File: tb/tb_lcd_hd44780_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_lcd_hd44780_ctrl
// Brief  : Self-checking bench for lcd_hd44780_ctrl against a schedule model.
// Rev    : 1.0
// ============================================================================
module tb_lcd_hd44780_ctrl;

    localparam int P   = 100;
    localparam int S   = 2;
    localparam int E   = 5;
    localparam int CW  = 20;
    localparam int CLW = 200;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       init_done;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon;

    always #5 clk = ~clk;

    lcd_hd44780_ctrl_if tb_if();

    lcd_hd44780_ctrl #(
        .POWERUP_CYCLES    (P),
        .SETUP_CYCLES      (S),
        .EN_CYCLES         (E),
        .CMD_WAIT_CYCLES   (CW),
        .CLEAR_WAIT_CYCLES (CLW)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .bus       (tb_if),
        .init_done (init_done),
        .LCD_DATA  (lcd_data),
        .LCD_RS    (lcd_rs),
        .LCD_RW    (lcd_rw),
        .LCD_EN    (lcd_en),
        .LCD_ON    (lcd_on),
        .LCD_BLON  (lcd_blon)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    logic [7:0] rom [6];
    initial begin
        rom[0] = 8'h38; rom[1] = 8'h38; rom[2] = 8'h38;
        rom[3] = 8'h0C; rom[4] = 8'h01; rom[5] = 8'h06;
    end

    // Model: list of transfers by load edge; every output is derived from it.
    int         xT  [64];
    logic       xrs [64];
    logic [7:0] xd  [64];
    int         nx       = 0;
    int         done_at  = 0;
    int         init_end = 0;
    int         acc_cnt  = 0;

    int         rise_n [16];
    logic [7:0] rise_d [16];
    int         n_rise     = 0;
    int         en_start   = 0;
    int         last_width = 0;
    logic       prev_en    = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int xlen(input logic rs, input logic [7:0] d);
        return 2 * S + E + ((!rs && d >= 8'h01 && d <= 8'h03) ? CLW : CW);
    endfunction

    task automatic model_reset();
        int t;
        t = P + 2;
        for (int i = 0; i < 6; i++) begin
            xT[i]   = t;
            xrs[i]  = 1'b0;
            xd[i]   = rom[i];
            done_at = t + xlen(1'b0, rom[i]);
            t       = done_at + 1;
        end
        nx       = 6;
        init_end = done_at;
        acc_cnt  = 0;
        n_rise   = 0;
        prev_en  = 1'b0;
        en_start = 0;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        int         n;
        int         k;
        logic       ers;
        logic [7:0] ed;
        logic       een;
        if (reset) begin
            check("rst_LCD_EN",   int'(lcd_en),   0);
            check("rst_LCD_DATA", int'(lcd_data), 0);
            check("rst_LCD_RS",   int'(lcd_rs),   0);
            check("rst_LCD_RW",   int'(lcd_rw),   0);
            check("rst_LCD_ON",   int'(lcd_on),   0);
            check("rst_LCD_BLON", int'(lcd_blon), 0);
            check("rst_ready",    int'(tb_if.req_ready), 0);
            check("rst_init_done", int'(init_done), 0);
            model_reset();
        end else begin
            n = cyc;
            k = -1;
            for (int i = 0; i < nx; i++) if (xT[i] <= n) k = i;
            if (k < 0) begin
                ers = 1'b0; ed = 8'h00; een = 1'b0;
            end else begin
                ers = xrs[k];
                ed  = xd[k];
                een = (n >= xT[k] + S) && (n < xT[k] + S + E);
            end
            check("LCD_DATA",  int'(lcd_data), int'(ed));
            check("LCD_RS",    int'(lcd_rs),   int'(ers));
            check("LCD_EN",    int'(lcd_en),   int'(een));
            check("LCD_RW",    int'(lcd_rw),   0);
            check("LCD_ON",    int'(lcd_on),   int'(n >= 1));
            check("LCD_BLON",  int'(lcd_blon), int'(n >= 1));
            check("req_ready", int'(tb_if.req_ready), int'(n >= done_at));
            check("init_done", int'(init_done), int'(n >= init_end));

            if (lcd_en && !prev_en) begin
                en_start = n;
                if (!init_done && n_rise < 16) begin
                    rise_n[n_rise] = n;
                    rise_d[n_rise] = lcd_data;
                    n_rise++;
                end
            end
            if (!lcd_en && prev_en) last_width = n - en_start;
            prev_en = lcd_en;

            if (n >= done_at && tb_if.req_valid === 1'b1 && nx < 64) begin
                xT[nx]  = n + 1;
                xrs[nx] = tb_if.req_rs;
                xd[nx]  = tb_if.req_data;
                done_at = n + 1 + xlen(tb_if.req_rs, tb_if.req_data);
                nx++;
                acc_cnt++;
            end
        end
    end

    // Returns one time unit after the accepting edge.
    task automatic wait_accept(output int k);
        int budget;
        budget = 3000;
        k = -1;
        while (budget > 0) begin
            @(negedge clk);
            if (tb_if.req_ready && tb_if.req_valid) begin
                @(posedge clk);
                #1;
                k = cyc;
                break;
            end
            budget--;
        end
        if (k < 0) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_ready(output int r);
        int budget;
        budget = 3000;
        r = -1;
        while (budget > 0) begin
            @(negedge clk);
            if (tb_if.req_ready) begin
                r = cyc;
                break;
            end
            budget--;
        end
        if (r < 0) check("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic rs, input logic [7:0] d, input int exp_gap);
        int k;
        int r;
        tb_if.req_rs    = rs;
        tb_if.req_data  = d;
        tb_if.req_valid = 1'b1;
        wait_accept(k);
        tb_if.req_valid = 1'b0;
        tb_if.req_rs    = 1'($urandom);
        tb_if.req_data  = 8'($urandom);
        wait_ready(r);
        check("ready_gap", r - k, exp_gap);
        check("en_width", last_width, E);
    endtask

    task automatic check_init_pulses();
        check("init_pulses", n_rise, 6);
        for (int i = 0; i < 6; i++) check("init_byte", int'(rise_d[i]), int'(rom[i]));
        check("first_en_rise", rise_n[0], 104);
        check("clear_gap_ge200", int'((rise_n[5] - rise_n[4] - E) >= 200), 1);
    endtask

    initial begin
        int k;
        int r;
        int budget;
        logic       rs;
        logic [7:0] d;

        tb_if.req_valid = 1'b1;
        tb_if.req_rs    = 1'b1;
        tb_if.req_data  = 8'h55;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;

        // Valid held from reset: single accept on the first IDLE cycle.
        wait_accept(k);
        tb_if.req_data  = 8'hAA;
        tb_if.req_valid = 1'b0;
        check("first_accept_edge", k, 462);
        check_init_pulses();
        wait_ready(r);
        check("single_accept", acc_cnt, 1);
        check("hold_data_55", int'(lcd_data), 8'h55);

        send(1'b1, 8'h41, 29);
        check("data_41", int'(lcd_data), 8'h41);
        send(1'b0, 8'h01, 209);
        send(1'b1, 8'h01, 29);

        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            rs = 1'($urandom_range(0, 1));
            d  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
            send(rs, d, xlen(rs, d));
        end

        // Asynchronous reset while EN is high.
        tb_if.req_rs    = 1'b1;
        tb_if.req_data  = 8'h42;
        tb_if.req_valid = 1'b1;
        wait_accept(k);
        tb_if.req_valid = 1'b0;
        budget = 50;
        while (!lcd_en && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("en_seen_before_reset", int'(lcd_en), 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_EN", int'(lcd_en), 0);
        check("async_rst_ON", int'(lcd_on), 0);
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        budget = 1000;
        while (!init_done && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("replay_init_done", int'(init_done), 1);
        check_init_pulses();
        repeat (5) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
